// File: rtl/fastserial_tx_arbiter.sv
// fastserial_tx_arbiter
// Shares the single fast-serial transmitter between two byte-stream sources.
// A source owns the link for a whole packet; owners alternate on ties. Each
// packet is optionally prefixed with a channel header byte. Every byte is paced
// against the transmitter busy flag. A source that stalls mid-packet loses the
// link after a programmable idle time.

module fastserial_tx_arbiter #(
    parameter bit          HDR_EN       = 1'b1,
    parameter logic [7:0]  HDR_BASE     = 8'hA0,
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_s0_valid,
    input  logic [7:0]  i_s0_data,
    input  logic        i_s0_last,
    output logic        o_s0_ready,
    input  logic        i_s1_valid,
    input  logic [7:0]  i_s1_data,
    input  logic        i_s1_last,
    output logic        o_s1_ready,
    output logic        o_tx_write,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_busy,
    output logic [1:0]  o_grant,
    output logic        o_abort,
    output logic [15:0] o_abort_count
);

    typedef enum logic [2:0] {
        ST_ARB   = 3'd0,
        ST_ISSUE = 3'd1,
        ST_GUARD = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FETCH = 3'd4
    } state_t;

    // Terminal counts: guard spans GUARD_CYCLES cycles, abort after IDLE_TIMEOUT stalls
    localparam logic [3:0]  GUARD_LAST_C = 4'(GUARD_CYCLES - 1);
    localparam logic [15:0] IDLE_LAST_C  = 16'(IDLE_TIMEOUT - 1);

    // Header byte: base value with bit 0 replaced by the source index
    function automatic logic [7:0] hdr_byte(input logic idx);
        return {HDR_BASE[7:1], idx};
    endfunction

    // Abort counter increment that holds at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    state_t      state_r,       state_nx_s;
    logic [1:0]  grant_r,       grant_nx_s;
    logic        last_grant_r,  last_grant_nx_s;
    logic [7:0]  tx_data_r,     tx_data_nx_s;
    logic        pkt_last_r,    pkt_last_nx_s;
    logic [3:0]  guard_cnt_r,   guard_cnt_nx_s;
    logic [15:0] idle_cnt_r,    idle_cnt_nx_s;
    logic        abort_r,       abort_nx_s;
    logic [15:0] abort_count_r, abort_count_nx_s;

    logic        tx_write_s;
    logic        s0_ready_s;
    logic        s1_ready_s;
    logic        src_valid_s;
    logic [7:0]  src_data_s;
    logic        src_last_s;
    logic        sel_s1_s;

    // Present the granted source's stream to the fetch logic
    always_comb begin
        if (grant_r[1]) begin
            src_valid_s = i_s1_valid;
            src_data_s  = i_s1_data;
            src_last_s  = i_s1_last;
        end else begin
            src_valid_s = i_s0_valid;
            src_data_s  = i_s0_data;
            src_last_s  = i_s0_last;
        end
    end

    // Next-state and output decode for the packet FSM
    always_comb begin
        state_nx_s       = state_r;
        grant_nx_s       = grant_r;
        last_grant_nx_s  = last_grant_r;
        tx_data_nx_s     = tx_data_r;
        pkt_last_nx_s    = pkt_last_r;
        guard_cnt_nx_s   = guard_cnt_r;
        idle_cnt_nx_s    = idle_cnt_r;
        abort_nx_s       = 1'b0;
        abort_count_nx_s = abort_count_r;
        tx_write_s       = 1'b0;
        s0_ready_s       = 1'b0;
        s1_ready_s       = 1'b0;
        // Source 1 wins when it is alone, or on a tie when source 0 went last
        sel_s1_s         = i_s1_valid && (!i_s0_valid || !last_grant_r);

        case (state_r)
            ST_ARB: begin
                idle_cnt_nx_s = 16'd0;
                if (i_s0_valid || i_s1_valid) begin
                    grant_nx_s      = sel_s1_s ? 2'b10 : 2'b01;
                    last_grant_nx_s = sel_s1_s;
                    if (HDR_EN) begin
                        tx_data_nx_s  = hdr_byte(sel_s1_s);
                        pkt_last_nx_s = 1'b0;
                        state_nx_s    = ST_ISSUE;
                    end else begin
                        state_nx_s    = ST_FETCH;
                    end
                end else begin
                    grant_nx_s = 2'b00;
                end
            end
            ST_ISSUE: begin
                if (!i_tx_busy) begin
                    tx_write_s     = 1'b1;
                    guard_cnt_nx_s = 4'd0;
                    state_nx_s     = ST_GUARD;
                end else begin
                    state_nx_s     = ST_ISSUE;
                end
            end
            ST_GUARD: begin
                // Busy may lag the write strobe, so it is not trusted here
                if (guard_cnt_r >= GUARD_LAST_C) begin
                    guard_cnt_nx_s = 4'd0;
                    state_nx_s     = ST_DRAIN;
                end else begin
                    guard_cnt_nx_s = guard_cnt_r + 4'd1;
                end
            end
            ST_DRAIN: begin
                if (!i_tx_busy) begin
                    if (pkt_last_r) begin
                        grant_nx_s = 2'b00;
                        state_nx_s = ST_ARB;
                    end else begin
                        idle_cnt_nx_s = 16'd0;
                        state_nx_s    = ST_FETCH;
                    end
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_FETCH: begin
                s0_ready_s = grant_r[0];
                s1_ready_s = grant_r[1];
                if (src_valid_s) begin
                    tx_data_nx_s  = src_data_s;
                    pkt_last_nx_s = src_last_s;
                    idle_cnt_nx_s = 16'd0;
                    state_nx_s    = ST_ISSUE;
                end else if (idle_cnt_r >= IDLE_LAST_C) begin
                    // Stalled source: drop the packet, keep last_grant so the other side wins next
                    abort_nx_s       = 1'b1;
                    abort_count_nx_s = sat_inc16(abort_count_r);
                    grant_nx_s       = 2'b00;
                    idle_cnt_nx_s    = 16'd0;
                    state_nx_s       = ST_ARB;
                end else begin
                    idle_cnt_nx_s = idle_cnt_r + 16'd1;
                end
            end
            default: begin
                grant_nx_s    = 2'b00;
                idle_cnt_nx_s = 16'd0;
                state_nx_s    = ST_ARB;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial packet
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r       <= ST_ARB;
            grant_r       <= 2'b00;
            last_grant_r  <= 1'b1;
            tx_data_r     <= 8'h00;
            pkt_last_r    <= 1'b0;
            guard_cnt_r   <= 4'd0;
            idle_cnt_r    <= 16'd0;
            abort_r       <= 1'b0;
            abort_count_r <= 16'd0;
        end else begin
            state_r       <= state_nx_s;
            grant_r       <= grant_nx_s;
            last_grant_r  <= last_grant_nx_s;
            tx_data_r     <= tx_data_nx_s;
            pkt_last_r    <= pkt_last_nx_s;
            guard_cnt_r   <= guard_cnt_nx_s;
            idle_cnt_r    <= idle_cnt_nx_s;
            abort_r       <= abort_nx_s;
            abort_count_r <= abort_count_nx_s;
        end
    end

    assign o_grant       = grant_r;
    assign o_tx_data     = tx_data_r;
    assign o_abort       = abort_r;
    assign o_abort_count = abort_count_r;
    assign o_tx_write    = tx_write_s;
    assign o_s0_ready    = s0_ready_s;
    assign o_s1_ready    = s1_ready_s;

endmodule

// File: tb/tb_fastserial_tx_arbiter.sv
// Directed bench for fastserial_tx_arbiter: queue-fed sources, an 8-cycle
// busy model of the transmitter, and per-scenario tasks with inline checks.

module tb_fastserial_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s0_valid = 1'b0, s1_valid = 1'b0;
    logic [7:0]  s0_data = 8'h00, s1_data = 8'h00;
    logic        s0_last = 1'b0, s1_last = 1'b0;
    logic        s0_ready, s1_ready;
    logic        tx_write;
    logic [7:0]  tx_data;
    logic        busy;
    logic        busy_force = 1'b0;
    logic [1:0]  grant;
    logic        abort_p;
    logic [15:0] abort_count;

    logic [3:0]  busy_cnt;
    logic        prev_write;
    int          viol_busy = 0, viol_consec = 0, viol_ready = 0;

    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    logic [7:0]  tx_q[$];
    bit          acc0 = 1'b0, acc1 = 1'b0;

    int checks_total = 0;
    int checks_passed = 0;

    fastserial_tx_arbiter #(
        .HDR_EN(1'b1),
        .HDR_BASE(8'hA0),
        .GUARD_CYCLES(2),
        .IDLE_TIMEOUT(16)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_s0_valid(s0_valid),
        .i_s0_data(s0_data),
        .i_s0_last(s0_last),
        .o_s0_ready(s0_ready),
        .i_s1_valid(s1_valid),
        .i_s1_data(s1_data),
        .i_s1_last(s1_last),
        .o_s1_ready(s1_ready),
        .o_tx_write(tx_write),
        .o_tx_data(tx_data),
        .i_tx_busy(busy),
        .o_grant(grant),
        .o_abort(abort_p),
        .o_abort_count(abort_count)
    );

    always #10 clk = ~clk;

    // Transmitter model: busy for 8 cycles after every write, plus a forced-busy override
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_cnt <= 4'd0;
        else if (tx_write) busy_cnt <= 4'd8;
        else if (busy_cnt != 4'd0) busy_cnt <= busy_cnt - 4'd1;
    end
    assign busy = busy_force | (busy_cnt != 4'd0);

    // Capture transmitted bytes and track link-level protocol violations
    always @(posedge clk) begin
        if (rst_n) begin
            if (tx_write) tx_q.push_back(tx_data);
            if (tx_write && busy) viol_busy <= viol_busy + 1;
            if (tx_write && prev_write) viol_consec <= viol_consec + 1;
            if ((s0_ready && grant !== 2'b01) || (s1_ready && grant !== 2'b10))
                viol_ready <= viol_ready + 1;
            prev_write <= tx_write;
        end else begin
            prev_write <= 1'b0;
        end
    end

    // Source 0 driver: present queue head, pop after a handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            acc0 = 1'b0; s0_valid = 1'b0; s0_data = 8'h00; s0_last = 1'b0;
        end else begin
            if (acc0 && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                s0_valid = 1'b1; s0_data = q0[0][7:0]; s0_last = q0[0][8];
            end else begin
                s0_valid = 1'b0; s0_data = 8'h00; s0_last = 1'b0;
            end
            acc0 = s0_valid && s0_ready;
        end
    end

    // Source 1 driver: present queue head, pop after a handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            acc1 = 1'b0; s1_valid = 1'b0; s1_data = 8'h00; s1_last = 1'b0;
        end else begin
            if (acc1 && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                s1_valid = 1'b1; s1_data = q1[0][7:0]; s1_last = q1[0][8];
            end else begin
                s1_valid = 1'b0; s1_data = 8'h00; s1_last = 1'b0;
            end
            acc1 = s1_valid && s1_ready;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        busy_force = 1'b0;
        q0.delete();
        q1.delete();
        step();
        step();
        tx_q.delete();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            step();
            if (q0.size() == 0 && q1.size() == 0 && grant === 2'b00) done = 1'b1;
        end
        checks_total++;
        if (!done) $display("FAIL %s_idle: not idle after %0d cycles", name, budget);
        else checks_passed++;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks_total++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b want 00", grant); else checks_passed++;
        checks_total++; if (tx_write !== 1'b0) $display("FAIL rst_write: got %b want 0", tx_write); else checks_passed++;
        checks_total++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) $display("FAIL rst_ready: got %b%b want 00", s0_ready, s1_ready); else checks_passed++;
        checks_total++; if (abort_p !== 1'b0) $display("FAIL rst_abort: got %b want 0", abort_p); else checks_passed++;
        checks_total++; if (tx_data !== 8'h00) $display("FAIL rst_txdata: got %h want 00", tx_data); else checks_passed++;
        checks_total++; if (abort_count !== 16'd0) $display("FAIL rst_abcnt: got %0d want 0", abort_count); else checks_passed++;
        rst_n = 1'b1;
        step();
        step();
        step();
        checks_total++; if (grant !== 2'b00 || tx_write !== 1'b0) $display("FAIL idle_quiet: grant %b write %b want 00/0", grant, tx_write); else checks_passed++;
    endtask

    task automatic test_single_packet();
        logic [7:0] exp_b[4];
        int g01, bad;
        bit ended;
        exp_b = '{8'hA0, 8'h11, 8'h22, 8'h33};
        reset_dut();
        q0.push_back({1'b0, 8'h11});
        q0.push_back({1'b0, 8'h22});
        q0.push_back({1'b1, 8'h33});
        step();  // arbitration cycle: valid just raised
        checks_total++; if (grant !== 2'b00) $display("FAIL sp_arb_grant: got %b want 00", grant); else checks_passed++;
        step();  // first granted cycle
        checks_total++; if (tx_write !== 1'b1 || tx_data !== 8'hA0) $display("FAIL sp_hdr_latency: write %b data %h want 1/a0", tx_write, tx_data); else checks_passed++;
        g01 = 0; bad = 0; ended = 1'b0;
        for (int n = 0; n < 200 && !ended; n++) begin
            if (grant === 2'b01) g01++;
            else if (grant === 2'b00) ended = 1'b1;
            else bad++;
            if (!ended) step();
        end
        checks_total++; if (!ended || g01 != 43 || bad != 0) $display("FAIL sp_grant_span: cycles %0d bad %0d ended %0d want 43/0/1", g01, bad, ended); else checks_passed++;
        checks_total++; if (tx_q.size() != 4) $display("FAIL sp_count: got %0d bytes want 4", tx_q.size()); else checks_passed++;
        for (int i = 0; i < 4; i++) begin
            checks_total++;
            if (i >= tx_q.size() || tx_q[i] !== exp_b[i]) $display("FAIL sp_byte%0d: got %h want %h", i, (i < tx_q.size()) ? tx_q[i] : 8'h00, exp_b[i]);
            else checks_passed++;
        end
    endtask

    task automatic test_tie();
        logic [7:0] exp_a[6];
        logic [7:0] exp_b[4];
        exp_a = '{8'hA0, 8'h5A, 8'h5B, 8'hA1, 8'h6A, 8'h6B};
        exp_b = '{8'hA0, 8'h7A, 8'hA1, 8'h7B};
        reset_dut();
        q0.push_back({1'b0, 8'h5A}); q0.push_back({1'b1, 8'h5B});
        q1.push_back({1'b0, 8'h6A}); q1.push_back({1'b1, 8'h6B});
        wait_idle("tie1", 400);
        checks_total++; if (tx_q.size() != 6) $display("FAIL tie1_count: got %0d want 6", tx_q.size()); else checks_passed++;
        for (int i = 0; i < 6; i++) begin
            checks_total++;
            if (i >= tx_q.size() || tx_q[i] !== exp_a[i]) $display("FAIL tie1_byte%0d: got %h want %h", i, (i < tx_q.size()) ? tx_q[i] : 8'h00, exp_a[i]);
            else checks_passed++;
        end
        tx_q.delete();
        q0.push_back({1'b1, 8'h7A});
        q1.push_back({1'b1, 8'h7B});
        wait_idle("tie2", 400);
        checks_total++; if (tx_q.size() != 4) $display("FAIL tie2_count: got %0d want 4", tx_q.size()); else checks_passed++;
        for (int i = 0; i < 4; i++) begin
            checks_total++;
            if (i >= tx_q.size() || tx_q[i] !== exp_b[i]) $display("FAIL tie2_byte%0d: got %h want %h", i, (i < tx_q.size()) ? tx_q[i] : 8'h00, exp_b[i]);
            else checks_passed++;
        end
    endtask

    task automatic test_atomicity();
        logic [7:0] exp_b[7];
        int early;
        bit done;
        exp_b = '{8'hA0, 8'h31, 8'h32, 8'h33, 8'hA1, 8'h41, 8'h42};
        reset_dut();
        q0.push_back({1'b0, 8'h31}); q0.push_back({1'b0, 8'h32}); q0.push_back({1'b1, 8'h33});
        for (int n = 0; n < 15; n++) step();
        q1.push_back({1'b0, 8'h41}); q1.push_back({1'b1, 8'h42});
        early = 0; done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            step();
            if (s1_ready === 1'b1 && (q0.size() != 0 || grant !== 2'b10)) early++;
            if (q0.size() == 0 && q1.size() == 0 && grant === 2'b00) done = 1'b1;
        end
        checks_total++; if (!done) $display("FAIL at_idle: not idle after 400 cycles"); else checks_passed++;
        checks_total++; if (early != 0) $display("FAIL at_s1_ready: early ready cycles %0d want 0", early); else checks_passed++;
        checks_total++; if (tx_q.size() != 7) $display("FAIL at_count: got %0d want 7", tx_q.size()); else checks_passed++;
        for (int i = 0; i < 7; i++) begin
            checks_total++;
            if (i >= tx_q.size() || tx_q[i] !== exp_b[i]) $display("FAIL at_byte%0d: got %h want %h", i, (i < tx_q.size()) ? tx_q[i] : 8'h00, exp_b[i]);
            else checks_passed++;
        end
    endtask

    task automatic test_timeout();
        logic [7:0] exp_b[4];
        bit seen;
        int k;
        exp_b = '{8'hA0, 8'h77, 8'hA1, 8'h88};
        reset_dut();
        q0.push_back({1'b0, 8'h77});
        q1.push_back({1'b1, 8'h88});
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            step();
            if (q0.size() == 0) seen = 1'b1;
        end
        checks_total++; if (!seen) $display("FAIL to_accept: s0 byte not taken within 100 cycles"); else checks_passed++;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            step();
            if (s0_ready === 1'b1) seen = 1'b1;
        end
        checks_total++; if (!seen) $display("FAIL to_fetch: no FETCH entry within 100 cycles"); else checks_passed++;
        k = 0; seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            step();
            k++;
            if (abort_p === 1'b1) seen = 1'b1;
        end
        checks_total++; if (!seen || k != 16) $display("FAIL to_latency: abort after %0d cycles (seen %0d) want 16", k, seen); else checks_passed++;
        checks_total++; if (abort_count !== 16'd1) $display("FAIL to_abcnt: got %0d want 1", abort_count); else checks_passed++;
        checks_total++; if (grant !== 2'b00) $display("FAIL to_grant_clr: got %b want 00", grant); else checks_passed++;
        step();
        checks_total++; if (abort_p !== 1'b0) $display("FAIL to_pulse: abort %b want 0", abort_p); else checks_passed++;
        wait_idle("to", 300);
        checks_total++; if (tx_q.size() != 4) $display("FAIL to_count: got %0d want 4", tx_q.size()); else checks_passed++;
        for (int i = 0; i < 4; i++) begin
            checks_total++;
            if (i >= tx_q.size() || tx_q[i] !== exp_b[i]) $display("FAIL to_byte%0d: got %h want %h", i, (i < tx_q.size()) ? tx_q[i] : 8'h00, exp_b[i]);
            else checks_passed++;
        end
    endtask

    task automatic test_busy_pacing();
        int writes;
        reset_dut();
        busy_force = 1'b1;
        q0.push_back({1'b1, 8'h44});
        writes = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (tx_write === 1'b1) writes++;
        end
        checks_total++; if (writes != 0 || tx_q.size() != 0) $display("FAIL bp_hold: writes %0d captured %0d want 0/0", writes, tx_q.size()); else checks_passed++;
        checks_total++; if (grant !== 2'b01) $display("FAIL bp_grant: got %b want 01", grant); else checks_passed++;
        busy_force = 1'b0;
        #1;
        checks_total++; if (tx_write !== 1'b1 || tx_data !== 8'hA0) $display("FAIL bp_release: write %b data %h want 1/a0", tx_write, tx_data); else checks_passed++;
        wait_idle("bp", 200);
        checks_total++;
        if (tx_q.size() != 2 || tx_q[0] !== 8'hA0 || tx_q[1] !== 8'h44) $display("FAIL bp_seq: got %0d bytes want a0,44", tx_q.size());
        else checks_passed++;
    endtask

    task automatic test_reset_mid_packet();
        bit seen;
        reset_dut();
        q0.push_back({1'b0, 8'h51}); q0.push_back({1'b0, 8'h52}); q0.push_back({1'b1, 8'h53});
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            step();
            if (tx_q.size() == 1) seen = 1'b1;
        end
        checks_total++; if (!seen) $display("FAIL rm_header: header not sent within 50 cycles"); else checks_passed++;
        step(); step(); step();  // now waiting in DRAIN on busy
        checks_total++; if (grant !== 2'b01 || tx_data !== 8'hA0) $display("FAIL rm_pre: grant %b data %h want 01/a0", grant, tx_data); else checks_passed++;
        rst_n = 1'b0;
        #1;
        checks_total++; if (grant !== 2'b00) $display("FAIL rm_grant: got %b want 00", grant); else checks_passed++;
        checks_total++; if (tx_data !== 8'h00) $display("FAIL rm_txdata: got %h want 00", tx_data); else checks_passed++;
        checks_total++; if (tx_write !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0 || abort_p !== 1'b0) $display("FAIL rm_strobes: write %b rdy %b%b abort %b want 0", tx_write, s0_ready, s1_ready, abort_p); else checks_passed++;
        q0.delete();
        q1.delete();
        step(); step();
        tx_q.delete();
        rst_n = 1'b1;
        step();
        q0.push_back({1'b1, 8'h61});
        q1.push_back({1'b1, 8'h62});
        wait_idle("rm", 300);
        checks_total++;
        if (tx_q.size() != 4 || tx_q[0] !== 8'hA0 || tx_q[1] !== 8'h61 || tx_q[2] !== 8'hA1 || tx_q[3] !== 8'h62)
            $display("FAIL rm_tie_after: got %0d bytes, first %h want a0,61,a1,62", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00);
        else checks_passed++;
    endtask

    task automatic test_invariants();
        checks_total++; if (viol_busy != 0) $display("FAIL inv_write_busy: got %0d want 0", viol_busy); else checks_passed++;
        checks_total++; if (viol_consec != 0) $display("FAIL inv_write_b2b: got %0d want 0", viol_consec); else checks_passed++;
        checks_total++; if (viol_ready != 0) $display("FAIL inv_ready_owner: got %0d want 0", viol_ready); else checks_passed++;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_tie();
        test_atomicity();
        test_timeout();
        test_busy_pacing();
        test_reset_mid_packet();
        test_invariants();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
